vc_fifo: RTL
============

VC_FIFO -- requirements
Module: vc_fifo

Interface
REQ-001 Parameter DATA_SIZE, default 4, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_SIZE, default 2, SHALL set the address width; depth = 2^ADDR_SIZE entries.
REQ-003 Parameter AF_THRESH, default 3, SHALL set the occupancy at or above which almost_full asserts.
REQ-004 Parameter AE_THRESH, default 1, SHALL set the occupancy at or below which almost_empty asserts.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 push  input  1  SHALL be the write request, driven by the push0/push1 output of the demux stage.
REQ-008 data_in  input  DATA_SIZE  SHALL be the write data, driven by the data0/data1 output of the demux stage.
REQ-009 pop  input  1  SHALL be the read request from the consumer.
REQ-010 data_out  output  DATA_SIZE  SHALL be the registered read data.
REQ-011 valid_out  output  1  SHALL mark data_out as holding a word read in the previous cycle.
REQ-012 full, empty  output  1 each  SHALL be the occupancy boundary flags.
REQ-013 almost_full, almost_empty  output  1 each  SHALL be the threshold flags.
REQ-014 count  output  ADDR_SIZE+1  SHALL be the current occupancy, 0 to 2^ADDR_SIZE.
REQ-015 error  output  1  SHALL be present only when FIFO_ERROR_EN is defined.

Function
REQ-016 A push SHALL be accepted when push=1 and (full=0 or a pop is accepted in the same cycle); the word is written at wr_ptr, and wr_ptr increments modulo depth.
REQ-017 A pop SHALL be accepted when pop=1 and empty=0; the word at rd_ptr is registered into data_out, and rd_ptr increments modulo depth.
REQ-018 Read latency SHALL be 1 cycle: valid_out=1 in the cycle after an accepted pop, else 0.
REQ-019 data_out SHALL hold its last value when no pop is accepted.
REQ-020 count SHALL change by +1 on push only, by -1 on pop only, and stay unchanged on both or neither.
REQ-021 Simultaneous push and pop on a full FIFO SHALL perform both, leaving count at depth.
REQ-022 Simultaneous push and pop on an empty FIFO SHALL accept the push only; valid_out=0 next cycle and count becomes 1.
REQ-023 Push while full without pop SHALL be ignored: memory, pointers and count are unchanged.
REQ-024 Pop while empty SHALL be ignored: data_out is unchanged and valid_out=0.
REQ-025 Flags SHALL be combinational from count: full = (count==depth), empty = (count==0), almost_full = (count>=AF_THRESH), almost_empty = (count<=AE_THRESH).
REQ-026 Pointer wrap from depth-1 to 0 SHALL be seamless, with no loss or duplication of words.

Reset
REQ-027 Asserting reset SHALL immediately clear wr_ptr, rd_ptr, count, data_out, valid_out and error, without waiting for clk.
REQ-028 During reset, empty=1, almost_empty=1, full=0 and almost_full=0; memory contents are don't-care.
REQ-029 Reset mid-operation SHALL discard all stored words; the first accepted push after deassertion is the first word popped.

Configuration
REQ-030 With FIFO_ERROR_EN defined, error SHALL be set one cycle after an ignored push (REQ-023) or ignored pop (REQ-024), and SHALL remain set until reset.
REQ-031 Without FIFO_ERROR_EN, the error port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset, then push 0x1,0x2,0x3,0x4 on consecutive cycles -> count=4, full=1, almost_full=1 from count 3, empty=0.
REQ-033 From full, pop 4 times -> data_out 0x1,0x2,0x3,0x4 each one cycle after its pop, with valid_out=1; then empty=1 and count=0.
REQ-034 From full, push 0x5 without pop -> count stays 4; with FIFO_ERROR_EN, error=1 next cycle and stays set.
REQ-035 From empty, push 0xA and pop in the same cycle -> count=1, valid_out=0; the next pop returns 0xA.
REQ-036 Run 10 push/pop pairs with count held at 2 to force pointer wrap -> output order equals input order, with no loss.
REQ-037 Assert reset asynchronously between clock edges while count=3 -> count=0, empty=1 and valid_out=0 without a clock edge.

Source files
------------

// File: rtl/vc_fifo.sv
// ============================================================================
//  Module      : vc_fifo
//  Description : Synchronous FIFO with registered read data, occupancy count,
//                boundary/threshold flags. Optional sticky error flag is
//                built when FIFO_ERROR_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_fifo #(
    parameter int DATA_SIZE = 4,
    parameter int ADDR_SIZE = 2,
    parameter int AF_THRESH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 pop,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count
`ifdef FIFO_ERROR_EN
    ,
    output logic                 error
`endif
);

    localparam int               DEPTH   = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] c_DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [ADDR_SIZE:0] c_AF    = AF_THRESH[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] c_AE    = AE_THRESH[ADDR_SIZE:0];

    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_ptr;
    logic [ADDR_SIZE:0]   r_count;
    logic [DATA_SIZE-1:0] r_data_out;
    logic                 r_valid_out;
    logic                 w_pop_acc;
    logic                 w_push_acc;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign w_pop_acc  = pop & ~empty;
    assign w_push_acc = push & (~full | w_pop_acc);

    assign full         = (r_count == c_DEPTH);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= c_AF);
    assign almost_empty = (r_count <= c_AE);
    assign count        = r_count;
    assign data_out     = r_data_out;
    assign valid_out    = r_valid_out;

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_pop_acc;
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_SIZE'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr   <= r_rd_ptr + ADDR_SIZE'(1);
                r_data_out <= r_mem[r_rd_ptr];
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + (ADDR_SIZE+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_SIZE+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FIFO_ERROR_EN
    logic r_error;
    logic w_bad_op;

    assign w_bad_op = (push & full & ~w_pop_acc) | (pop & empty);
    assign error    = r_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_bad_op) begin
            r_error <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire
